onehot_decoder: RTL

- Registered binary-to-one-hot decoder with valid/ready on both sides.
- Inverse of the 8-to-3 priority encoder: takes a code such as 3'b011 and returns a one-hot vector such as 8'b00001000.
- A 2-entry skid buffer lets the upstream producer keep streaming while the consumer stalls.
- Sits between encoded-index producers and per-line consumers (request lines, enables).

---
 rtl/onehot_decoder_pkg.sv | 40 ++++
 rtl/onehot_skid_buf.sv | 89 ++++++++
 rtl/onehot_decoder.sv | 106 ++++++++++
 3 files changed

// File: rtl/onehot_decoder_pkg.sv
// ---------------------------------------------------------------------------
// onehot_decoder_pkg
//   Shared types and helpers for the registered binary-to-one-hot decoder.
//   - occ_state_e : occupancy of the two-entry skid buffer (EMPTY/ONE/TWO)
//   - entry_t     : one decoded entry {err, onehot}, sized for the widest
//                   legal decoder (32 lines); narrower decoders use the low
//                   OUT_W bits and leave the rest at zero.
//   - decode_code : binary code -> entry_t, flagging codes >= out_w.
// ---------------------------------------------------------------------------
package onehot_decoder_pkg;

    localparam int ONEHOT_MAX_W = 32;
    localparam int CODE_MAX_W   = 5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_state_e;

    typedef struct packed {
        logic                    err;
        logic [ONEHOT_MAX_W-1:0] onehot;
    } entry_t;

    // Codes outside the decoder's line count produce an all-zero vector and
    // raise err; this can only happen when out_w is not a power of two.
    function automatic entry_t decode_code(input logic [CODE_MAX_W-1:0] code,
                                           input int unsigned           out_w);
        entry_t e;
        e = '0;
        if (32'(code) < out_w) begin
            e.onehot = ONEHOT_MAX_W'(1) << code;
        end else begin
            e.err = 1'b1;
        end
        return e;
    endfunction

endpackage

// File: rtl/onehot_skid_buf.sv
// ---------------------------------------------------------------------------
// onehot_skid_buf
//   Two-entry valid/ready FIFO (head + tail) carrying decoded entries.
//   The output is driven straight from the head register; the ready to the
//   producer depends only on registered occupancy.
//
//   Ports
//     clk          in   clock, all state on posedge
//     rst          in   synchronous active-low reset
//     in_valid_i   in   producer offers in_data_i
//     in_data_i    in   entry to store
//     in_ready_o   out  buffer not full
//     out_valid_o  out  head entry present
//     out_data_o   out  head entry
//     out_ready_i  in   consumer takes the head entry
// ---------------------------------------------------------------------------
module onehot_skid_buf
    import onehot_decoder_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   in_valid_i,
    input  entry_t in_data_i,
    output logic   in_ready_o,
    output logic   out_valid_o,
    output entry_t out_data_o,
    input  logic   out_ready_i
);

    occ_state_e state_q, state_d;
    entry_t     head_q,  head_d;
    entry_t     tail_q,  tail_d;

    logic push;
    logic pop;

    assign in_ready_o  = (state_q != TWO);
    assign out_valid_o = (state_q != EMPTY);
    assign out_data_o  = head_q;

    assign push = in_valid_i & in_ready_o;
    assign pop  = out_valid_o & out_ready_i;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            EMPTY: begin
                if (push) begin
                    head_d  = in_data_i;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (push && !pop) begin
                    tail_d  = in_data_i;
                    state_d = TWO;
                end else if (!push && pop) begin
                    state_d = EMPTY;
                end else if (push && pop) begin
                    // Head leaves and the new entry takes its place.
                    head_d  = in_data_i;
                end
            end
            TWO: begin
                // Full: no push possible, only drain tail into head.
                if (pop) begin
                    head_d  = tail_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule

// File: rtl/onehot_decoder.sv
// ---------------------------------------------------------------------------
// onehot_decoder
//   Registered binary-to-one-hot decoder with valid/ready on both sides and a
//   two-entry skid buffer. Codes are decoded at push time; the output comes
//   only from the buffer head register (one cycle latency, no in->out path).
//
//   Parameters
//     OUT_W   one-hot width, 2..32
//     IN_W    code width, derived as $clog2(OUT_W); do not override
//
//   Ports
//     clk         in   clock
//     rst         in   synchronous active-low reset
//     in_code     in   binary code
//     in_valid    in   in_code valid
//     in_ready    out  block can accept a code
//     out_onehot  out  one-hot of head entry
//     out_err     out  head entry's code was >= OUT_W
//     out_valid   out  out_onehot/out_err valid
//     out_ready   in   consumer accepts head entry
//
//   Optional (macro ONEHOT_DECODER_STATUS_EN):
//     err_sticky  out  set when an err entry is pushed, cleared by reset
//     xfer_count  out  16-bit wrapping count of output transfers
// ---------------------------------------------------------------------------
module onehot_decoder
    import onehot_decoder_pkg::*;
#(
    parameter int OUT_W = 8,
    parameter int IN_W  = $clog2(OUT_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in_code,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_onehot,
    output logic             out_err,
    output logic             out_valid,
`ifdef ONEHOT_DECODER_STATUS_EN
    output logic             err_sticky,
    output logic [15:0]      xfer_count,
`endif
    input  logic             out_ready
);

    logic [CODE_MAX_W-1:0] code_ext;
    entry_t                dec;
    entry_t                head;
    logic                  unused_head_bits;

    assign code_ext = CODE_MAX_W'(in_code);
    assign dec      = decode_code(code_ext, OUT_W);

    onehot_skid_buf u_skid (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_data_i   (dec),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .out_data_o  (head),
        .out_ready_i (out_ready)
    );

    assign out_onehot = head.onehot[OUT_W-1:0];
    assign out_err    = head.err;

    // Lines above OUT_W are always zero; fold them so they count as consumed.
    assign unused_head_bits = ^head.onehot;

`ifdef ONEHOT_DECODER_STATUS_EN
    logic        push;
    logic        pop;
    logic        err_sticky_q, err_sticky_d;
    logic [15:0] xfer_count_q, xfer_count_d;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        err_sticky_d = err_sticky_q;
        xfer_count_d = xfer_count_q;
        if (push && dec.err) begin
            err_sticky_d = 1'b1;
        end
        if (pop) begin
            xfer_count_d = xfer_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_sticky_q <= 1'b0;
            xfer_count_q <= 16'd0;
        end else begin
            err_sticky_q <= err_sticky_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    assign err_sticky = err_sticky_q;
    assign xfer_count = xfer_count_q;
`endif

endmodule
